vdb_vga_timing_gen: RTL



---
 rtl/vdb_vga_timing_gen_if.sv | 47 ++++
 rtl/vdb_vga_timing_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vdb_vga_timing_gen_if.sv
// Purpose : pixel-source and VGA-output bundle of vdb_vga_timing_gen.
// Latency : none (wires only).
// Backpressure: none; the timing generator free-runs and the source must keep up.
//
// Signals:
//   pix_x/pix_y/pix_req : counter position offered to the external pixel source
//   pix_r/pix_g/pix_b   : external pixel colour for (pix_x, pix_y)
//   vga_r/g/b, vga_hs, vga_vs, vga_de : registered VGA outputs
//   frame_start/line_start : one-clk pulses aligned with the first active pixel
// modport master = timing generator, modport slave = pixel source / monitor.

interface vdb_vga_timing_gen_if #(
  parameter int XW      = 10,
  parameter int YW      = 10,
  parameter int COLOR_W = 4
);

  logic [XW-1:0]      pix_x;
  logic [YW-1:0]      pix_y;
  logic               pix_req;
  logic [COLOR_W-1:0] pix_r;
  logic [COLOR_W-1:0] pix_g;
  logic [COLOR_W-1:0] pix_b;
  logic [COLOR_W-1:0] vga_r;
  logic [COLOR_W-1:0] vga_g;
  logic [COLOR_W-1:0] vga_b;
  logic               vga_hs;
  logic               vga_vs;
  logic               vga_de;
  logic               frame_start;
  logic               line_start;

  modport master (
    output pix_x, pix_y, pix_req,
    input  pix_r, pix_g, pix_b,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de,
    output frame_start, line_start
  );

  modport slave (
    input  pix_x, pix_y, pix_req,
    output pix_r, pix_g, pix_b,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de,
    input  frame_start, line_start
  );

endinterface

// File: rtl/vdb_vga_timing_gen.sv
// Purpose : parametrised VGA sync/DE/colour generator with pixel-clock divider.
// Latency : one pixel period (CLK_DIV clk) from counter value to vga_* outputs.
// Backpressure: none; external pixel source must answer within CLK_DIV clk.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   en           run enable; low clears divider/counters and idles outputs
//   pattern_sel  0 external, 1 colour bars, 2 checkerboard, 3 grey ramp
//   vga_if       master side of vdb_vga_timing_gen_if (pixel source + VGA outputs)
//
// Build option: define VDB_VGA_PATTERN_EN to compile in the test-pattern
// generator. Without it pattern_sel is ignored and colour always comes from
// pix_r/g/b.

module vdb_vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int COLOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            pattern_sel,
  vdb_vga_timing_gen_if.master  vga_if
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);

  // Sync windows in counter units (line order: active, FP, sync, BP).
  localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int H_SYNC_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int V_SYNC_END = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [COLOR_W-1:0] C_FULL = '1;
  localparam logic [COLOR_W-1:0] C_ZERO = '0;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DW-1:0]      div_q,         div_d;
  logic [XW-1:0]      hc_q,          hc_d;
  logic [YW-1:0]      vc_q,          vc_d;
  logic [COLOR_W-1:0] vga_r_q,       vga_r_d;
  logic [COLOR_W-1:0] vga_g_q,       vga_g_d;
  logic [COLOR_W-1:0] vga_b_q,       vga_b_d;
  logic               vga_hs_q,      vga_hs_d;
  logic               vga_vs_q,      vga_vs_d;
  logic               vga_de_q,      vga_de_d;
  logic               frame_start_q, frame_start_d;
  logic               line_start_q,  line_start_d;

  // Pixel-rate strobe. With CLK_DIV=1 every clock is a pixel.
  logic tick;
  assign tick = (CLK_DIV == 1) ? 1'b1 : (div_q == DIV_LAST);

  // ---------------------------------------------------------------------------
  // Decode of the current (pre-increment) counter position
  // ---------------------------------------------------------------------------
  logic de_now;
  logic hs_now;
  logic vs_now;
  logic fs_now;
  logic ls_now;

  always_comb begin
    de_now = (int'(hc_q) < H_ACTIVE) && (int'(vc_q) < V_ACTIVE);
    hs_now = ((int'(hc_q) >= H_SYNC_BEG) && (int'(hc_q) < H_SYNC_END)) ? HS_POL : ~HS_POL;
    vs_now = ((int'(vc_q) >= V_SYNC_BEG) && (int'(vc_q) < V_SYNC_END)) ? VS_POL : ~VS_POL;
    fs_now = (hc_q == '0) && (vc_q == '0);
    ls_now = (hc_q == '0) && (int'(vc_q) < V_ACTIVE);
  end

  // ---------------------------------------------------------------------------
  // Colour source selection
  // ---------------------------------------------------------------------------
  logic [COLOR_W-1:0] src_r;
  logic [COLOR_W-1:0] src_g;
  logic [COLOR_W-1:0] src_b;

`ifdef VDB_VGA_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;
  // Working width wide enough for hc[5], vc[5] and hc[COLOR_W+1:2] even on
  // tiny timings; upper bits are zero-extended.
  localparam int GW0 = (XW > YW) ? XW : YW;
  localparam int GW1 = (GW0 > COLOR_W + 2) ? GW0 : COLOR_W + 2;
  localparam int GW  = (GW1 > 6) ? GW1 : 6;

  logic [2:0]    bar_idx;
  logic [GW-1:0] hc_w;
  logic [GW-1:0] vc_w;
  logic          chk_on;

  always_comb begin
    // Bar index by threshold compare rather than a divider.
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (int'(hc_q) >= i * BAR_W) begin
        bar_idx = 3'(i);
      end
    end

    hc_w   = GW'(hc_q);
    vc_w   = GW'(vc_q);
    chk_on = |((hc_w ^ vc_w) & GW'(32));

    src_r = vga_if.pix_r;
    src_g = vga_if.pix_g;
    src_b = vga_if.pix_b;
    case (pattern_sel)
      2'd1: begin
        // white, yellow, cyan, green, magenta, red, blue, black
        src_r = bar_idx[1] ? C_ZERO : C_FULL;
        src_g = bar_idx[2] ? C_ZERO : C_FULL;
        src_b = bar_idx[0] ? C_ZERO : C_FULL;
      end
      2'd2: begin
        src_r = chk_on ? C_FULL : C_ZERO;
        src_g = chk_on ? C_FULL : C_ZERO;
        src_b = chk_on ? C_FULL : C_ZERO;
      end
      2'd3: begin
        src_r = COLOR_W'(hc_w >> 2);
        src_g = COLOR_W'(hc_w >> 2);
        src_b = COLOR_W'(hc_w >> 2);
      end
      default: begin
        src_r = vga_if.pix_r;
        src_g = vga_if.pix_g;
        src_b = vga_if.pix_b;
      end
    endcase
  end
`else
  // Generator not built: pattern_sel has no effect.
  logic [1:0] sel_unused;
  assign sel_unused = pattern_sel;

  always_comb begin
    src_r = vga_if.pix_r;
    src_g = vga_if.pix_g;
    src_b = vga_if.pix_b;
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state: divider, counters and output register
  // ---------------------------------------------------------------------------
  always_comb begin
    div_d         = div_q;
    hc_d          = hc_q;
    vc_d          = vc_q;
    vga_r_d       = vga_r_q;
    vga_g_d       = vga_g_q;
    vga_b_d       = vga_b_q;
    vga_hs_d      = vga_hs_q;
    vga_vs_d      = vga_vs_q;
    vga_de_d      = vga_de_q;
    frame_start_d = 1'b0;
    line_start_d  = 1'b0;

    if (!en) begin
      // Idle looks exactly like reset so a restart begins at pixel (0,0).
      div_d    = '0;
      hc_d     = '0;
      vc_d     = '0;
      vga_r_d  = C_ZERO;
      vga_g_d  = C_ZERO;
      vga_b_d  = C_ZERO;
      vga_hs_d = ~HS_POL;
      vga_vs_d = ~VS_POL;
      vga_de_d = 1'b0;
    end else begin
      div_d = tick ? '0 : div_q + DW'(1);

      if (tick) begin
        if (hc_q == H_LAST) begin
          hc_d = '0;
          vc_d = (vc_q == V_LAST) ? '0 : vc_q + YW'(1);
        end else begin
          hc_d = hc_q + XW'(1);
        end

        // Output register captures the position the counters held before
        // this tick, giving one pixel period of latency for all fields.
        vga_de_d      = de_now;
        vga_hs_d      = hs_now;
        vga_vs_d      = vs_now;
        vga_r_d       = de_now ? src_r : C_ZERO;
        vga_g_d       = de_now ? src_g : C_ZERO;
        vga_b_d       = de_now ? src_b : C_ZERO;
        frame_start_d = fs_now;
        line_start_d  = ls_now;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q         <= '0;
      hc_q          <= '0;
      vc_q          <= '0;
      vga_r_q       <= C_ZERO;
      vga_g_q       <= C_ZERO;
      vga_b_q       <= C_ZERO;
      vga_hs_q      <= ~HS_POL;
      vga_vs_q      <= ~VS_POL;
      vga_de_q      <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      div_q         <= div_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
      vga_de_q      <= vga_de_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign vga_if.pix_x       = hc_q;
  assign vga_if.pix_y       = vc_q;
  assign vga_if.pix_req     = de_now;
  assign vga_if.vga_r       = vga_r_q;
  assign vga_if.vga_g       = vga_g_q;
  assign vga_if.vga_b       = vga_b_q;
  assign vga_if.vga_hs      = vga_hs_q;
  assign vga_if.vga_vs      = vga_vs_q;
  assign vga_if.vga_de      = vga_de_q;
  assign vga_if.frame_start = frame_start_q;
  assign vga_if.line_start  = line_start_q;

endmodule
